lp_sample_queue: RTL and testbench

- Circular sample buffer that sits directly upstream of the low-pass FIR stage.
- Stores incoming stereo PCM samples at the audio rate.
- On each new sample, once primed, streams the most recent TAPS samples (oldest first) to the FIR together with the sequencing strobe it needs to run one MAC pass.
- Left and right share one address stream held in one dual-port memory.

---
 rtl/eq_pkg.sv | 15 +
 rtl/lp_dp_ram.sv | 38 +++
 rtl/lp_sample_queue.sv | 120 ++++++++++++
 tb/tb_lp_sample_queue.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer low-pass path: tap/depth
// constants, the signed sample type and the sample-queue state encoding.
package eq_pkg;

    localparam int LP_TAPS  = 1021;
    localparam int LP_DEPTH = 1024;

    typedef logic signed [15:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } q_state_t;

endpackage

// File: rtl/lp_dp_ram.sv
// Simple dual-port sample store: one write port and one synchronous read
// port with 1-cycle latency. Left sample lives in [31:16], right in [15:0].
// The array itself is never reset; only the read data register is, so the
// streamed outputs come up as zero. The read register only loads when re is
// high, which lets the outputs hold their value between readout passes.
module lp_dp_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Write port: store the stereo pair at waddr.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered read, holding the last word when not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lp_sample_queue.sv
// Circular stereo sample buffer feeding the low-pass FIR. Every incoming
// sample is stored; once TAPS samples are held, each new sample launches a
// readout pass that streams the latest TAPS samples oldest-first while
// sequencing is high for TAPS+1 cycles. A sample arriving mid-pass queues
// exactly one follow-up pass, separated by one low cycle so the FIR re-arms.
module lp_sample_queue
    import eq_pkg::*;
#(
    parameter int DEPTH = LP_DEPTH,
    parameter int TAPS  = LP_TAPS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt_smpl,
    input  logic [15:0] lft_smpl,
    input  logic [15:0] rght_smpl,
    output logic        sequencing,
    output logic [15:0] lft_out,
    output logic [15:0] rght_out
);

    // TAPS < DEPTH, so both fit in the address width.
    localparam logic [AW-1:0] TAPS_W  = AW'(TAPS);
    localparam logic [AW-1:0] TAPS_M1 = AW'(TAPS - 1);

    q_state_t      state;
    logic [AW-1:0] new_ptr;
    logic [AW-1:0] count;
    logic          pending;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_cnt;

    logic [AW-1:0] ptr_after;
    logic [AW-1:0] win_start;
    logic          trigger;
    logic          last_rd;
    logic          rd_en;
    logic [31:0]   rdata;

    // Window bookkeeping: where the newest-TAPS window starts if a pass
    // launches this cycle (a write in the same cycle is included).
    always_comb begin
        ptr_after = new_ptr + {{(AW-1){1'b0}}, wrt_smpl};
        win_start = ptr_after - TAPS_W;
        trigger   = wrt_smpl && ((count == TAPS_M1) || (count == TAPS_W));
        last_rd   = (rd_cnt == TAPS_W);
        rd_en     = (state == SEQ) && !last_rd;
    end

    // Write pointer and saturating fill count; writes are taken in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_ptr <= '0;
            count   <= '0;
        end else if (wrt_smpl) begin
            new_ptr <= ptr_after;
            if (count != TAPS_W) begin
                count <= count + 1'b1;
            end
        end
    end

    // Readout FSM: launches passes, walks the window and remembers at most
    // one sample that arrived while a pass was already running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sequencing <= 1'b0;
            pending    <= 1'b0;
            rd_addr    <= '0;
            rd_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger || pending) begin
                        state      <= SEQ;
                        sequencing <= 1'b1;
                        pending    <= 1'b0;
                        rd_addr    <= win_start;
                        rd_cnt     <= '0;
                    end
                end
                SEQ: begin
                    rd_addr <= rd_addr + 1'b1;
                    rd_cnt  <= rd_cnt + 1'b1;
                    if (wrt_smpl) begin
                        pending <= 1'b1;
                    end
                    if (last_rd) begin
                        state      <= IDLE;
                        sequencing <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    sequencing <= 1'b0;
                end
            endcase
        end
    end

    lp_dp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wrt_smpl),
        .waddr (new_ptr),
        .wdata ({lft_smpl, rght_smpl}),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rdata)
    );

    assign lft_out  = rdata[31:16];
    assign rght_out = rdata[15:0];

endmodule

// File: tb/tb_lp_sample_queue.sv
// Directed bench for lp_sample_queue at full size (1024 entries, 1021 taps).
// Keeps a history of every written sample and checks each readout pass
// against the newest 1021 entries of that history.
module tb_lp_sample_queue;

    localparam int TAPS = 1021;

    logic        clk;
    logic        rst_n;
    logic        wrt_smpl;
    logic [15:0] lft_smpl;
    logic [15:0] rght_smpl;
    logic        sequencing;
    logic [15:0] lft_out;
    logic [15:0] rght_out;

    int checks;
    int errors;
    int hist_l[$];
    int hist_r[$];

    int p_len;
    int p_bad;
    int p_bad_j;
    int p_bad_v;
    int p_exp_v;

    lp_sample_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrt_smpl   (wrt_smpl),
        .lft_smpl   (lft_smpl),
        .rght_smpl  (rght_smpl),
        .sequencing (sequencing),
        .lft_out    (lft_out),
        .rght_out   (rght_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one sample across a single clock edge; returns 1 time unit
    // after that edge.
    task automatic write_sample(input int v);
        wrt_smpl  = 1'b1;
        lft_smpl  = 16'(v);
        rght_smpl = 16'(-v);
        hist_l.push_back(v);
        hist_r.push_back(-v);
        @(posedge clk); #1;
        wrt_smpl = 1'b0;
    endtask

    // Follows a running pass until sequencing drops (bounded), recording
    // its length and the first streamed sample that differs from the
    // history window. Optionally injects up to two writes at given cycles.
    task automatic measure_pass(input int inj_a, input int val_a,
                                input int inj_b, input int val_b);
        int base;
        base    = hist_l.size() - TAPS;
        p_len   = 0;
        p_bad   = 0;
        p_bad_j = -1;
        p_bad_v = 0;
        p_exp_v = 0;
        while (sequencing === 1'b1 && p_len < 2 * TAPS) begin
            if (p_len >= 1) begin
                if (lft_out !== 16'(hist_l[base + p_len - 1]) ||
                    rght_out !== 16'(hist_r[base + p_len - 1])) begin
                    if (p_bad == 0) begin
                        p_bad_j = p_len;
                        p_bad_v = int'($signed(lft_out));
                        p_exp_v = hist_l[base + p_len - 1];
                    end
                    p_bad++;
                end
            end
            if (p_len == inj_a) begin
                wrt_smpl  = 1'b1;
                lft_smpl  = 16'(val_a);
                rght_smpl = 16'(-val_a);
                hist_l.push_back(val_a);
                hist_r.push_back(-val_a);
            end else if (p_len == inj_b) begin
                wrt_smpl  = 1'b1;
                lft_smpl  = 16'(val_b);
                rght_smpl = 16'(-val_b);
                hist_l.push_back(val_b);
                hist_r.push_back(-val_b);
            end else begin
                wrt_smpl = 1'b0;
            end
            @(posedge clk); #1;
            p_len++;
        end
        wrt_smpl = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sequencing !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_seq: got %b expected 0", sequencing);
        end
        checks++;
        if (lft_out !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_lft: got %0d expected 0", lft_out);
        end
        checks++;
        if (rght_out !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_rght: got %0d expected 0", rght_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_below(input int offset, input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 1; k <= TAPS - 1; k++) begin
            write_sample(offset + k);
            repeat (2) begin
                if (sequencing !== 1'b0) seen = 1'b1;
                @(posedge clk); #1;
            end
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_no_pass: got seq seen=%b expected 0", name, seen);
        end
    endtask

    task automatic test_first_pass();
        write_sample(TAPS);
        checks++;
        if (sequencing !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_rise: got %b expected 1", sequencing);
        end
        measure_pass(-1, 0, -1, 0);
        checks++;
        if (p_len != TAPS + 1) begin
            errors++;
            $display("[TB] FAIL first_len: got %0d expected %0d", p_len, TAPS + 1);
        end
        checks++;
        if (p_bad != 0) begin
            errors++;
            $display("[TB] FAIL first_data: cycle %0d got %0d expected %0d (%0d bad)",
                     p_bad_j, p_bad_v, p_exp_v, p_bad);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (lft_out !== 16'd1021 || rght_out !== 16'(-1021)) begin
            errors++;
            $display("[TB] FAIL first_hold: got %0d/%0d expected 1021/-1021",
                     $signed(lft_out), $signed(rght_out));
        end
    endtask

    task automatic test_sliding();
        for (int k = 1022; k <= 1030; k++) begin
            write_sample(k);
            checks++;
            if (sequencing !== 1'b1) begin
                errors++;
                $display("[TB] FAIL slide_rise_%0d: got %b expected 1", k, sequencing);
            end
            measure_pass(-1, 0, -1, 0);
            checks++;
            if (p_len != TAPS + 1 || p_bad != 0) begin
                errors++;
                $display("[TB] FAIL slide_pass_%0d: len %0d bad %0d at cycle %0d got %0d expected %0d",
                         k, p_len, p_bad, p_bad_j, p_bad_v, p_exp_v);
            end
            repeat (3) @(posedge clk);
            #1;
        end
        checks++;
        if (lft_out !== 16'd1030) begin
            errors++;
            $display("[TB] FAIL slide_last: got %0d expected 1030", lft_out);
        end
    endtask

    task automatic test_write_during_seq();
        logic seen;
        // Single write at high cycle 500.
        write_sample(1031);
        measure_pass(500, 5000, -1, 0);
        checks++;
        if (p_len != TAPS + 1 || p_bad != 0) begin
            errors++;
            $display("[TB] FAIL mid_first_pass: len %0d bad %0d at cycle %0d got %0d expected %0d",
                     p_len, p_bad, p_bad_j, p_bad_v, p_exp_v);
        end
        @(posedge clk); #1;
        checks++;
        if (sequencing !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_gap: got seq %b after one low cycle expected 1", sequencing);
        end
        measure_pass(-1, 0, -1, 0);
        checks++;
        if (p_len != TAPS + 1 || p_bad != 0) begin
            errors++;
            $display("[TB] FAIL mid_second_pass: len %0d bad %0d at cycle %0d got %0d expected %0d",
                     p_len, p_bad, p_bad_j, p_bad_v, p_exp_v);
        end
        checks++;
        if (lft_out !== 16'd5000 || rght_out !== 16'(-5000)) begin
            errors++;
            $display("[TB] FAIL mid_last_sample: got %0d/%0d expected 5000/-5000",
                     $signed(lft_out), $signed(rght_out));
        end
        // Two writes in one pass yield exactly one extra pass.
        repeat (4) @(posedge clk);
        #1;
        write_sample(6000);
        measure_pass(100, 6001, 700, 6002);
        @(posedge clk); #1;
        checks++;
        if (sequencing !== 1'b1) begin
            errors++;
            $display("[TB] FAIL two_gap: got seq %b expected 1", sequencing);
        end
        measure_pass(-1, 0, -1, 0);
        checks++;
        if (p_len != TAPS + 1 || p_bad != 0 || lft_out !== 16'd6002) begin
            errors++;
            $display("[TB] FAIL two_extra_pass: len %0d bad %0d last %0d expected last 6002",
                     p_len, p_bad, lft_out);
        end
        seen = 1'b0;
        repeat (50) begin
            if (sequencing !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL two_only_one_extra: got seq seen=%b expected 0", seen);
        end
    endtask

    task automatic test_edge_events();
        logic seen;
        // Write on the final high cycle still counts as pending.
        write_sample(7000);
        measure_pass(TAPS, 7001, -1, 0);
        @(posedge clk); #1;
        checks++;
        if (sequencing !== 1'b1) begin
            errors++;
            $display("[TB] FAIL final_cycle_pending: got seq %b expected 1", sequencing);
        end
        // Write during the re-arm low cycle is absorbed into this pass.
        measure_pass(-1, 0, -1, 0);
        checks++;
        if (p_len != TAPS + 1 || p_bad != 0 || lft_out !== 16'd7001) begin
            errors++;
            $display("[TB] FAIL final_cycle_pass: len %0d bad %0d last %0d expected last 7001",
                     p_len, p_bad, lft_out);
        end
        repeat (3) @(posedge clk);
        #1;
        write_sample(7100);
        measure_pass(10, 7101, -1, 0);
        write_sample(7102);
        checks++;
        if (sequencing !== 1'b1) begin
            errors++;
            $display("[TB] FAIL absorb_rise: got seq %b expected 1", sequencing);
        end
        measure_pass(-1, 0, -1, 0);
        checks++;
        if (p_len != TAPS + 1 || p_bad != 0 || lft_out !== 16'd7102) begin
            errors++;
            $display("[TB] FAIL absorb_pass: len %0d bad %0d last %0d expected last 7102",
                     p_len, p_bad, lft_out);
        end
        seen = 1'b0;
        repeat (50) begin
            if (sequencing !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL absorb_single: got seq seen=%b expected 0", seen);
        end
    endtask

    task automatic test_reset_mid_pass();
        write_sample(8000);
        repeat (300) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sequencing !== 1'b0 || lft_out !== 16'd0 || rght_out !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got seq %b lft %0d rght %0d expected 0/0/0",
                     sequencing, lft_out, rght_out);
        end
        hist_l.delete();
        hist_r.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_fill_below(2000, "refill");
        write_sample(2000 + TAPS);
        checks++;
        if (sequencing !== 1'b1) begin
            errors++;
            $display("[TB] FAIL refill_rise: got %b expected 1", sequencing);
        end
        measure_pass(-1, 0, -1, 0);
        checks++;
        if (p_len != TAPS + 1 || p_bad != 0) begin
            errors++;
            $display("[TB] FAIL refill_pass: len %0d bad %0d at cycle %0d got %0d expected %0d",
                     p_len, p_bad, p_bad_j, p_bad_v, p_exp_v);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        wrt_smpl  = 1'b0;
        lft_smpl  = '0;
        rght_smpl = '0;
        rst_n     = 1'b0;
        test_reset();
        test_fill_below(0, "fill");
        test_first_pass();
        test_sliding();
        test_write_during_seq();
        test_edge_events();
        test_reset_mid_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
